elm_neuron_mac: RTL and testbench
=================================

// Module: elm_neuron_mac
// PURPOSE
//  Hidden-layer neuron datapath, directly downstream of the per-neuron weight memory.
//  Streams one input sample per accepted beat and drives the weight memory read port in step.
//  Multiplies each sample by its weight and accumulates with saturation.
//  Once numWeight products are summed, adds the bias and emits one fixed-point pre-activation result.
// PARAMETERS
//  dataWidth     16   width of input, weight, bias and output (signed, two's complement)
//  addressWidth  10   weight memory address width; raddr is addressWidth+1 bits
//  numWeight     784  products per frame (inputs per neuron), 1..2**addressWidth
//  fracBits      8    fractional bits of input/weight/bias/output (Q format)
// PORTS
//  clk           in   1              clock, all logic on rising edge
//  rst           in   1              synchronous reset, active-high
//  myinput       in   dataWidth      input sample, signed Q(fracBits)
//  myinputValid  in   1              sample valid; every valid beat is accepted (no backpressure)
//  bias          in   dataWidth      neuron bias, signed Q(fracBits), stable during a frame
//  ren           out  1              weight memory read enable
//  wen           out  1              weight memory write enable, tied 0
//  raddr         out  addressWidth+1 weight memory read address
//  wout          in   dataWidth      weight memory read data, valid 1 cycle after ren
//  out           out  dataWidth      neuron result, signed Q(fracBits)
//  outvalid      out  1              1-cycle pulse, out valid
// BEHAVIOUR
//  Reset: raddr=0, out=0, outvalid=0, accumulator=0, product count=0, all pipeline valids=0.
//  ren = myinputValid (combinational); raddr is a registered counter pointing at the next weight.
//  raddr increments on each valid beat; it wraps numWeight-1 -> 0.
//  Pipeline, input accepted at cycle T:
//   T:   ren=1, raddr=k
//   T+1: wout=w[k]; myinput registered alongside as x_d
//   T+2: mul <= x_d*wout (2*dataWidth signed, 2*fracBits frac); mulValid=1
//   T+3: sum <= sat(sum+mul)
//  Saturating add: if both operands have the same sign and the result sign differs,
//   clamp to 2^(2dw-1)-1 or -2^(2dw-1).
//  Last product of a frame (count==numWeight-1 at T+3):
//   - finalSum <= sat(sum+mul); sum <= 0; count <= 0.
//  T+4:
//   - tmp = sat(finalSum + (sign-extended bias << fracBits)) >>> fracBits (arithmetic)
//   - out <= tmp clamped to [-2^(dw-1), 2^(dw-1)-1]; outvalid=1 for exactly one cycle
//  Latency: last valid input -> outvalid = 4 cycles, regardless of gaps within the frame.
//  Gaps: cycles with myinputValid=0 advance nothing; the pipeline stages hold valid=0.
//  Back-to-back frames: the first input of frame n+1 may directly follow the last of frame n.
//   Its product lands in the cleared sum at T+4; there are no stalls and no cross-frame mixing.
//  out holds its value between pulses; it changes only on outvalid.
//  Reset mid-frame: partial sum and in-flight pipeline data are discarded, no outvalid,
//   and raddr returns to 0.
//  bias is sampled at T+4 of the last input.
// TESTING (bench uses a behavioural weight memory with 1-cycle read latency; numWeight=4, fracBits=8)
//  1 Weights {1.0,2.0,3.0,4.0}=0x0100..0x0400, inputs all 0x0100, bias 0x0080, contiguous
//    -> out=0x0A80 with outvalid 4 cycles after the last input; raddr sequence 0,1,2,3,0.
//  2 Same stimulus as 1 with 1-3 idle cycles between inputs -> out=0x0A80, latency 4 after last input.
//  3 Weights 0x7FFF, inputs 0x7FFF, bias 0x7FFF -> out=0x7FFF;
//    inputs 0x8000 with weights 0x7FFF -> out=0x8000 (saturation both signs).
//  4 Two back-to-back frames: frame 1 as test 1; frame 2 has inputs 0xFF00 (-1.0), bias 0
//    -> outvalid pulses 4 cycles apart with out=0x0A80 then 0xF600.
//  5 Assert rst after 2 inputs of a frame, then send a full frame as test 1
//    -> no pulse for the aborted frame; one pulse with out=0x0A80; raddr restarts at 0.
//  6 Check that wen=0 on every cycle and that ren equals myinputValid throughout tests 1-5.

Source files
------------

// File: rtl/elm_neuron_mac.sv
// Hidden-layer neuron datapath: streams samples, reads one weight per sample,
// accumulates saturating products and emits a biased, rescaled pre-activation.
module elm_neuron_mac #(
  parameter int unsigned dataWidth    = 16,
  parameter int unsigned addressWidth = 10,
  parameter int unsigned numWeight    = 784,
  parameter int unsigned fracBits     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [dataWidth-1:0]    myinput,
  input  logic                    myinputValid,
  input  logic [dataWidth-1:0]    bias,
  output logic                    ren,
  output logic                    wen,
  output logic [addressWidth:0]   raddr,
  input  logic [dataWidth-1:0]    wout,
  output logic [dataWidth-1:0]    out,
  output logic                    outvalid
);

  localparam int unsigned AccW = 2 * dataWidth;
  localparam int unsigned CntW = $clog2(numWeight + 1);

  localparam logic signed [AccW-1:0] AccMax = {1'b0, {(AccW-1){1'b1}}};
  localparam logic signed [AccW-1:0] AccMin = {1'b1, {(AccW-1){1'b0}}};
  localparam logic signed [AccW-1:0] OutMax =
    {{(AccW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [AccW-1:0] OutMin =
    {{(AccW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};
  localparam logic [addressWidth:0] LastAddr = (addressWidth+1)'(numWeight - 1);
  localparam logic [CntW-1:0]       LastCnt  = CntW'(numWeight - 1);

  // Two's-complement add that clamps instead of wrapping on overflow.
  function automatic logic signed [AccW-1:0] sat_add(input logic signed [AccW-1:0] a,
                                                     input logic signed [AccW-1:0] b);
    logic signed [AccW-1:0] s;
    s = a + b;
    if ((a[AccW-1] == b[AccW-1]) && (s[AccW-1] != a[AccW-1])) begin
      s = a[AccW-1] ? AccMin : AccMax;
    end
    return s;
  endfunction

  logic [addressWidth:0]         raddr_q;
  logic signed [dataWidth-1:0]   x_q;
  logic                          in_valid_q;
  logic signed [AccW-1:0]        mul_q;
  logic                          mul_valid_q;
  logic signed [AccW-1:0]        sum_q;
  logic [CntW-1:0]               cnt_q;
  logic signed [AccW-1:0]        final_sum_q;
  logic                          fin_valid_q;
  logic [dataWidth-1:0]          out_q;
  logic                          outvalid_q;

  logic signed [AccW-1:0]        sum_next;
  logic                          is_last;
  logic signed [AccW-1:0]        bias_ext;
  logic signed [AccW-1:0]        biased;
  logic signed [AccW-1:0]        shifted;
  logic [dataWidth-1:0]          out_d;

  // Weight read address: advances once per accepted sample, wraps at the frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q <= '0;
    end else if (myinputValid) begin
      raddr_q <= (raddr_q == LastAddr) ? '0 : raddr_q + 1'b1;
    end
  end

  // Stage 1: hold the sample so it lines up with the weight returned by memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      in_valid_q <= 1'b0;
    end else begin
      x_q        <= myinput;
      in_valid_q <= myinputValid;
    end
  end

  // Stage 2: full-precision signed product.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_q       <= '0;
      mul_valid_q <= 1'b0;
    end else begin
      mul_q       <= x_q * $signed(wout);
      mul_valid_q <= in_valid_q;
    end
  end

  // Stage 3 next-state: saturating accumulate and last-product detect.
  always_comb begin
    sum_next = sat_add(sum_q, mul_q);
    is_last  = (cnt_q == LastCnt);
  end

  // Stage 3: accumulate; on the last product hand off the total and clear for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cnt_q       <= '0;
      final_sum_q <= '0;
      fin_valid_q <= 1'b0;
    end else begin
      fin_valid_q <= mul_valid_q && is_last;
      if (mul_valid_q) begin
        if (is_last) begin
          final_sum_q <= sum_next;
          sum_q       <= '0;
          cnt_q       <= '0;
        end else begin
          sum_q <= sum_next;
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

  // Stage 4 next-state: add bias aligned to product scale, rescale, clamp to output width.
  always_comb begin
    bias_ext = {{dataWidth{bias[dataWidth-1]}}, bias};
    bias_ext = bias_ext <<< fracBits;
    biased   = sat_add(final_sum_q, bias_ext);
    shifted  = biased >>> fracBits;
    if (shifted > OutMax) begin
      out_d = OutMax[dataWidth-1:0];
    end else if (shifted < OutMin) begin
      out_d = OutMin[dataWidth-1:0];
    end else begin
      out_d = shifted[dataWidth-1:0];
    end
  end

  // Stage 4: result register updates only on a frame completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      outvalid_q <= 1'b0;
    end else begin
      outvalid_q <= fin_valid_q;
      if (fin_valid_q) begin
        out_q <= out_d;
      end
    end
  end

  // Outputs: read enable follows the sample strobe; the memory is never written here.
  always_comb begin
    ren      = myinputValid;
    wen      = 1'b0;
    raddr    = raddr_q;
    out      = out_q;
    outvalid = outvalid_q;
  end

endmodule

// File: tb/tb_elm_neuron_mac.sv
// Bench for elm_neuron_mac: frame table plus reset-abort sequence, with an
// expected-result queue checked against each outvalid pulse.
module tb_elm_neuron_mac;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NW = 4;
  localparam int FB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] myinput;
  logic          myinputValid;
  logic [DW-1:0] bias;
  logic          ren;
  logic          wen;
  logic [AW:0]   raddr;
  logic [DW-1:0] wout;
  logic [DW-1:0] out;
  logic          outvalid;

  elm_neuron_mac #(
    .dataWidth   (DW),
    .addressWidth(AW),
    .numWeight   (NW),
    .fracBits    (FB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .myinput     (myinput),
    .myinputValid(myinputValid),
    .bias        (bias),
    .ren         (ren),
    .wen         (wen),
    .raddr       (raddr),
    .wout        (wout),
    .out         (out),
    .outvalid    (outvalid)
  );

  always #5 clk = ~clk;

  // Behavioural weight memory, one-cycle read latency.
  logic [DW-1:0] mem [2**(AW+1)];
  always @(posedge clk) if (ren) wout <= mem[raddr];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  typedef struct {
    logic [DW-1:0] val;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  // Monitor state, all produced by the bench.
  bit          mon_en = 1'b0;
  logic [AW:0] exp_raddr = '0;
  logic [DW-1:0] exp_out = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("wen", 32'(wen), 32'd0);
      chk("ren", 32'(ren), 32'(myinputValid));
      chk("raddr", 32'(raddr), 32'(exp_raddr));
      if (outvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_outvalid", 32'(outvalid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out", 32'(out), 32'(e.val));
          chk("latency_cycle", 32'(cycle), 32'(e.due));
          exp_out = e.val;
        end
      end else begin
        chk("out_hold", 32'(out), 32'(exp_out));
      end
      // Model the effect of the coming edge.
      if (rst) begin
        exp_raddr = '0;
        exp_out   = '0;
      end else if (myinputValid) begin
        exp_raddr = (exp_raddr == AW'(NW - 1)) ? '0 : exp_raddr + 1'b1;
      end
    end
  end

  typedef struct {
    logic [NW-1:0][DW-1:0] w;
    logic [NW-1:0][DW-1:0] x;
    logic [DW-1:0]         b;
    int                    maxgap;
    bit                    b2b;
    logic [DW-1:0]         exp;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame; bias changes only after this frame's last sample so a
  // preceding frame still sees its own bias when it completes.
  task automatic drive_frame(input vec_t v, input bit push);
    for (int j = 0; j < NW; j++) begin
      myinput      = v.x[j];
      myinputValid = 1'b1;
      if (push && j == NW - 1) begin
        exp_t e;
        e.val = v.exp;
        e.due = cycle + 4;
        exp_q.push_back(e);
      end
      step();
      myinputValid = 1'b0;
      if (v.maxgap > 0 && j < NW - 1) begin
        repeat ($urandom_range(1, v.maxgap)) step();
      end
    end
    bias = v.b;
  endtask

  task automatic load_weights(input logic [NW-1:0][DW-1:0] w);
    for (int k = 0; k < NW; k++) mem[k] = w[k];
  endtask

  initial begin
    logic [NW-1:0][DW-1:0] w_ramp;
    logic [NW-1:0][DW-1:0] x_one;
    int guard;
    w_ramp = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    x_one  = {4{16'h0100}};
    vecs[0] = '{w: w_ramp, x: x_one, b: 16'h0080, maxgap: 0, b2b: 0, exp: 16'h0A80};
    vecs[1] = '{w: w_ramp, x: x_one, b: 16'h0080, maxgap: 3, b2b: 0, exp: 16'h0A80};
    vecs[2] = '{w: {4{16'h7FFF}}, x: {4{16'h7FFF}}, b: 16'h7FFF, maxgap: 0, b2b: 0,
                exp: 16'h7FFF};
    vecs[3] = '{w: {4{16'h7FFF}}, x: {4{16'h8000}}, b: 16'h0000, maxgap: 0, b2b: 0,
                exp: 16'h8000};
    vecs[4] = '{w: w_ramp, x: x_one, b: 16'h0080, maxgap: 0, b2b: 1, exp: 16'h0A80};
    vecs[5] = '{w: w_ramp, x: {4{16'hFF00}}, b: 16'h0000, maxgap: 0, b2b: 0,
                exp: 16'hF600};

    for (int k = 0; k < 2**(AW+1); k++) mem[k] = '0;
    rst          = 1'b1;
    myinput      = '0;
    myinputValid = 1'b0;
    bias         = 16'h0080;
    step();
    mon_en = 1'b1;
    step();
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_outvalid", 32'(outvalid), 32'd0);
    chk("reset_raddr", 32'(raddr), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      load_weights(vecs[i].w);
      drive_frame(vecs[i], 1'b1);
      if (!vecs[i].b2b) repeat (6) step();
    end

    // Abort a frame with reset after two samples, then send a clean frame.
    load_weights(w_ramp);
    bias = 16'h0080;
    myinput      = 16'h0100;
    myinputValid = 1'b1;
    step();
    step();
    myinputValid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_raddr", 32'(raddr), 32'd0);
    chk("abort_out", 32'(out), 32'd0);
    drive_frame(vecs[0], 1'b1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
